pipeline_ctrl: RTL and testbench

//  Central sequencer for the 5-stage riscv_cpu pipeline (PC/IF/ID/EX/MEM/WB).

---
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: start gating, load-use stalls, branch flushes,
// EX operand forwarding and halt draining. Define PIPE_PERF_EN to build the stall/flush counters.
module pipeline_ctrl #(
    parameter int          NSTG         = 6,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_INST    = 32'h00000073
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic [31:0]     id_inst,
    input  logic            id_rs1_re,
    input  logic [4:0]      id_rs1_addr,
    input  logic            id_rs2_re,
    input  logic [4:0]      id_rs2_addr,
    input  logic            ex_rd_we,
    input  logic [4:0]      ex_rd_addr,
    input  logic            ex_is_load,
    input  logic            mem_rd_we,
    input  logic [4:0]      mem_rd_addr,
    input  logic            br,
    output logic            br_take,
    output logic [NSTG-1:0] do_stall,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            running,
    output logic            halt,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [NSTG-1:0] STALL_FRONT = NSTG'(7);

    state_t        state;
    logic [CW-1:0] drain_cnt;
    logic          lu;

    assign lu = ex_is_load && ex_rd_we && (ex_rd_addr != 5'd0) &&
                ((id_rs1_re && (id_rs1_addr == ex_rd_addr)) ||
                 (id_rs2_re && (id_rs2_addr == ex_rd_addr)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (go) state <= RUN;
                RUN: begin
                    if ((id_inst == HALT_INST) && !lu) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) state <= HALTED;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= HALTED;
            endcase
        end
    end

    assign running   = (state == RUN);
    assign halt      = (state == HALTED);
    assign state_dbg = state;

    // Load-use takes precedence over a branch; the branch is re-resolved once data forwards.
    always_comb begin
        br_take     = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        do_stall    = '1;
        case (state)
            RUN: begin
                if (lu) begin
                    do_stall    = STALL_FRONT;
                    flush_id_ex = 1'b1;
                end else if (br) begin
                    br_take     = 1'b1;
                    flush_if_id = 1'b1;
                    do_stall    = '0;
                end else begin
                    do_stall    = '0;
                end
            end
            DRAIN: begin
                do_stall    = STALL_FRONT;
                flush_id_ex = 1'b1;
            end
            default: ;
        endcase
    end

    // A load in EX has no result yet, so only non-load EX writers forward.
    function automatic logic [1:0] fwd_sel(input logic re, input logic [4:0] rs,
                                           input logic ex_we, input logic [4:0] ex_rd,
                                           input logic ex_ld, input logic mem_we,
                                           input logic [4:0] mem_rd);
        if (!re || rs == 5'd0)                return 2'b00;
        if (ex_we && !ex_ld && ex_rd == rs)   return 2'b01;
        if (mem_we && mem_rd == rs)           return 2'b10;
        return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(id_rs1_re, id_rs1_addr, ex_rd_we, ex_rd_addr, ex_is_load,
                           mem_rd_we, mem_rd_addr);
    assign fwd_b = fwd_sel(id_rs2_re, id_rs2_addr, ex_rd_we, ex_rd_addr, ex_is_load,
                           mem_rd_we, mem_rd_addr);

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (running && lu && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (br_take && flush_cnt != 16'hFFFF)       flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0;
    assign flush_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: start-up, load-use, forwarding, branch and halt/drain.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset, go, id_rs1_re, id_rs2_re, ex_rd_we, ex_is_load, mem_rd_we, br;
  logic [31:0] id_inst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr;
  logic        br_take, flush_if_id, flush_id_ex, running, halt;
  logic [5:0]  do_stall;
  logic [1:0]  fwd_a, fwd_b, state_dbg;
  logic [15:0] stall_cnt, flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset), .go(go), .id_inst(id_inst),
    .id_rs1_re(id_rs1_re), .id_rs1_addr(id_rs1_addr),
    .id_rs2_re(id_rs2_re), .id_rs2_addr(id_rs2_addr),
    .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
    .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .br(br),
    .br_take(br_take), .do_stall(do_stall), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .running(running), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    go = 0; id_inst = 32'h0; br = 0;
    id_rs1_re = 0; id_rs1_addr = 0; id_rs2_re = 0; id_rs2_addr = 0;
    ex_rd_we = 0; ex_rd_addr = 0; ex_is_load = 0; mem_rd_we = 0; mem_rd_addr = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [5:0] stall, input logic bt,
                            input logic fif, input logic fie);
    check({tag, ".do_stall"}, {26'h0, do_stall}, {26'h0, stall});
    check({tag, ".br_take"}, {31'h0, br_take}, {31'h0, bt});
    check({tag, ".flush_if_id"}, {31'h0, flush_if_id}, {31'h0, fif});
    check({tag, ".flush_id_ex"}, {31'h0, flush_id_ex}, {31'h0, fie});
  endtask

  task automatic set_load_use();
    ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = 5;
    id_rs1_re = 1; id_rs1_addr = 5;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;

    // idle with go low
    for (int i = 0; i < 10; i++) begin
      check("idle.do_stall", {26'h0, do_stall}, 32'h3F);
      check("idle.running", {31'h0, running}, 32'h0);
      next_cycle();
    end
    check_ctrl("idle", 6'h3F, 0, 0, 0);
    check("idle.halt", {31'h0, halt}, 32'h0);
    check("idle.fwd_a", {30'h0, fwd_a}, 32'h0);
    check("idle.stall_cnt", {16'h0, stall_cnt}, 32'h0);

    // start
    go = 1; #1;
    check("go.same_cycle", {26'h0, do_stall}, 32'h3F);
    next_cycle();
    go = 0; #1;
    check("run.running", {31'h0, running}, 32'h1);
    check_ctrl("run", 6'h00, 0, 0, 0);

    // load-use: LW x5 in EX, ADD rs1=x5 in ID
    set_load_use(); #1;
    check_ctrl("lu", 6'b000111, 0, 0, 1);
    check("lu.fwd_a", {30'h0, fwd_a}, 32'h0);
    next_cycle();
    ex_is_load = 0; ex_rd_we = 0; mem_rd_we = 1; mem_rd_addr = 5; #1;
    check_ctrl("lu_after", 6'h00, 0, 0, 0);
    check("lu_after.fwd_a", {30'h0, fwd_a}, 32'h2);
    check("lu_after.running", {31'h0, running}, 32'h1);

    // forwarding priority and x0
    clear_inputs();
    ex_rd_we = 1; ex_rd_addr = 3; mem_rd_we = 1; mem_rd_addr = 3;
    id_rs2_re = 1; id_rs2_addr = 3; id_rs1_re = 1; id_rs1_addr = 0; #1;
    check("fwd.b_ex_prio", {30'h0, fwd_b}, 32'h1);
    check("fwd.a_x0", {30'h0, fwd_a}, 32'h0);
    ex_rd_addr = 0; #1;
    check("fwd.a_x0_exrd0", {30'h0, fwd_a}, 32'h0);
    check("fwd.b_mem", {30'h0, fwd_b}, 32'h2);
    id_rs2_re = 0; #1;
    check("fwd.b_no_re", {30'h0, fwd_b}, 32'h0);
    ex_rd_addr = 7; id_rs1_addr = 7; #1;
    check("fwd.a_ex", {30'h0, fwd_a}, 32'h1);
    next_cycle();

    // branch deferred by load-use, then taken
    clear_inputs();
    set_load_use(); br = 1; #1;
    check_ctrl("br_lu", 6'b000111, 0, 0, 1);
    next_cycle();
    ex_is_load = 0; #1;
    check_ctrl("br_take", 6'h00, 1, 1, 0);
    next_cycle();
    clear_inputs(); #1;
    check("perf.stall_cnt", {16'h0, stall_cnt}, PERF ? 32'd2 : 32'd0);
    check("perf.flush_cnt", {16'h0, flush_cnt}, PERF ? 32'd1 : 32'd0);

    // halt held off by load-use
    id_inst = 32'h00000073; set_load_use(); #1;
    next_cycle();
    check("halt_lu.running", {31'h0, running}, 32'h1);

    // halt and drain
    clear_inputs(); id_inst = 32'h00000073; #1;
    check("halt_inst.running", {31'h0, running}, 32'h1);
    next_cycle();
    id_inst = 32'h0; br = 1; #1;
    for (int k = 0; k < 4; k++) begin
      check_ctrl("drain", 6'b000111, 0, 0, 1);
      check("drain.running", {31'h0, running}, 32'h0);
      check("drain.halt", {31'h0, halt}, 32'h0);
      next_cycle();
    end
    br = 0; #1;
    check("halted.halt", {31'h0, halt}, 32'h1);
    check_ctrl("halted", 6'h3F, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      go = (k % 2 == 0); #1;
      next_cycle();
      check("halted.go_ignored", {31'h0, halt}, 32'h1);
    end
    go = 0;

    // reset from HALTED, then reset in the second drain cycle
    reset = 1; next_cycle(); reset = 0; #1;
    check("rst.halt", {31'h0, halt}, 32'h0);
    check("rst.state", {30'h0, state_dbg}, 32'h0);
    check("rst.stall_cnt", {16'h0, stall_cnt}, 32'h0);
    check("rst.flush_cnt", {16'h0, flush_cnt}, 32'h0);
    go = 1; next_cycle(); go = 0;
    id_inst = 32'h00000073; #1;
    next_cycle();
    id_inst = 32'h0; #1;
    check("drain1.state", {30'h0, state_dbg}, 32'h2);
    next_cycle();
    reset = 1; #1;
    check_ctrl("drain2", 6'b000111, 0, 0, 1);
    next_cycle();
    reset = 0; #1;
    check("drain_rst.halt", {31'h0, halt}, 32'h0);
    check("drain_rst.running", {31'h0, running}, 32'h0);
    check_ctrl("drain_rst", 6'h3F, 0, 0, 0);
    repeat (6) next_cycle();
    check("drain_rst.stays_idle", {31'h0, halt}, 32'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running sim expected finish");
    $fatal(1, "timeout");
  end

endmodule
